// File: rtl/matmul_pkg.sv
// Shared types and defaults for the matmul sequencer: FSM state enum,
// array-geometry defaults and counter-width helpers.
package matmul_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_LOAD_W,
    S_STREAM,
    S_DRAIN,
    S_DONE
  } matmul_seq_state_t;

  localparam int DEF_ROWS           = 4;
  localparam int DEF_COLS           = 4;
  localparam int DEF_HOLD_CYCLES    = 2;
  localparam int DEF_TIMEOUT_CYCLES = 256;

  function automatic int vcnt_w(input int rows, input int hold);
    return $clog2(rows * hold) + 1;
  endfunction

  function automatic int sel_w(input int rows);
    return (rows > 1) ? $clog2(rows) : 1;
  endfunction

  localparam int DEF_VCNT_W = vcnt_w(DEF_ROWS, DEF_HOLD_CYCLES);
  localparam int DEF_SEL_W  = sel_w(DEF_ROWS);

endpackage

// File: rtl/matmul_sequencer_col_valid_counter.sv
// Per-column saturating count of output-valid cycles; complete once the
// column has delivered every held output word.
module col_valid_counter #(
  parameter int TARGET = 8,
  parameter int CNTW   = 4
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_clear,
  input  logic i_inc,
  output logic o_complete
);

  logic [CNTW-1:0] r_cnt;

  assign o_complete = (r_cnt == CNTW'(TARGET));

  // Clear reloads with this cycle's valid so the clear cycle itself counts.
  always_ff @(posedge i_clk) begin
    if (i_rst)                    r_cnt <= '0;
    else if (i_clear)             r_cnt <= CNTW'(i_inc);
    else if (i_inc && !o_complete) r_cnt <= r_cnt + CNTW'(1);
  end

endmodule

// File: rtl/matmul_sequencer.sv
// Control FSM for one weight-stationary matmul: clear, load weights, stream
// inputs, drain outputs, pulse done. Drain watchdog under MATMUL_SEQ_TIMEOUT_EN.
module matmul_sequencer
  import matmul_pkg::*;
#(
  parameter int ROWS           = DEF_ROWS,
  parameter int COLS           = DEF_COLS,
  parameter int HOLD_CYCLES    = DEF_HOLD_CYCLES,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_start,
  input  logic [COLS-1:0]        i_matmul_output_valid,
  output logic                   o_busy,
  output logic                   o_done,
  output logic                   o_array_clear,
  output logic                   o_weight_load_en,
  output logic [sel_w(ROWS)-1:0] o_weight_row_sel,
  output logic                   o_input_feed_en,
  output logic [sel_w(ROWS)-1:0] o_input_row_sel,
  output logic                   o_timeout_err
);

  localparam int SELW   = sel_w(ROWS);
  localparam int TARGET = ROWS * HOLD_CYCLES;
  localparam int CNTW   = vcnt_w(ROWS, HOLD_CYCLES);
  localparam logic [SELW-1:0] LAST_ROW = SELW'(ROWS - 1);

  matmul_seq_state_t r_state, w_next;
  logic [SELW-1:0]   r_wsel, r_isel;
  logic [COLS-1:0]   w_col_complete;
  logic              w_all_done;
  logic              w_timeout;

  assign w_all_done = &w_col_complete;

  for (genvar c = 0; c < COLS; c++) begin : g_col
    col_valid_counter #(.TARGET(TARGET), .CNTW(CNTW)) u_cnt (
      .i_clk      (i_clk),
      .i_rst      (i_rst),
      .i_clear    (r_state == S_CLEAR),
      .i_inc      (i_matmul_output_valid[c] && (r_state != S_IDLE)),
      .o_complete (w_col_complete[c])
    );
  end

`ifdef MATMUL_SEQ_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES) + 1;
  logic [TW-1:0] r_drain_cnt;
  logic          r_timeout_err;

  assign w_timeout     = (r_state == S_DRAIN) && (r_drain_cnt == TW'(TIMEOUT_CYCLES - 1));
  assign o_timeout_err = r_timeout_err;

  always_ff @(posedge i_clk) begin
    if (i_rst || r_state != S_DRAIN) r_drain_cnt <= '0;
    else                             r_drain_cnt <= r_drain_cnt + TW'(1);
  end

  // Normal completion on the expiry cycle wins over the error flag.
  always_ff @(posedge i_clk) begin
    if (i_rst || r_state == S_CLEAR)    r_timeout_err <= 1'b0;
    else if (w_timeout && !w_all_done)  r_timeout_err <= 1'b1;
  end
`else
  assign w_timeout     = 1'b0;
  assign o_timeout_err = 1'b0;
`endif

  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (i_start) w_next = S_CLEAR;
      S_CLEAR:  w_next = S_LOAD_W;
      S_LOAD_W: if (r_wsel == LAST_ROW) w_next = S_STREAM;
      S_STREAM: if (r_isel == LAST_ROW) w_next = w_all_done ? S_DONE : S_DRAIN;
      S_DRAIN:  if (w_all_done || w_timeout) w_next = S_DONE;
      S_DONE:   w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wsel <= '0;
      r_isel <= '0;
    end else begin
      if (r_state == S_LOAD_W) r_wsel <= (r_wsel == LAST_ROW) ? '0 : r_wsel + SELW'(1);
      if (r_state == S_STREAM) r_isel <= (r_isel == LAST_ROW) ? '0 : r_isel + SELW'(1);
    end
  end

  assign o_busy           = (r_state != S_IDLE);
  assign o_done           = (r_state == S_DONE);
  assign o_array_clear    = (r_state == S_CLEAR);
  assign o_weight_load_en = (r_state == S_LOAD_W);
  assign o_input_feed_en  = (r_state == S_STREAM);
  assign o_weight_row_sel = r_wsel;
  assign o_input_row_sel  = r_isel;

endmodule

// File: tb/tb_matmul_sequencer.sv
// Directed bench for matmul_sequencer (ROWS=COLS=4, HOLD=2, TIMEOUT=16).
// The watchdog scenario runs only when MATMUL_SEQ_TIMEOUT_EN is defined.
module tb_matmul_sequencer;

  logic       clk = 1'b0;
  logic       rst, start;
  logic [3:0] vld;
  logic       busy, done, clr, wle, ife, tmo;
  logic [1:0] wsel, isel;

  int n_cmp = 0;
  int n_bad = 0;

  matmul_sequencer #(.ROWS(4), .COLS(4), .HOLD_CYCLES(2), .TIMEOUT_CYCLES(16)) dut (
    .i_clk                 (clk),
    .i_rst                 (rst),
    .i_start               (start),
    .i_matmul_output_valid (vld),
    .o_busy                (busy),
    .o_done                (done),
    .o_array_clear         (clr),
    .o_weight_load_en      (wle),
    .o_weight_row_sel      (wsel),
    .o_input_feed_en       (ife),
    .o_input_row_sel       (isel),
    .o_timeout_err         (tmo)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all(input string tag, input bit e_busy, input bit e_done, input bit e_clr,
                         input bit e_wle, input int e_wsel, input bit e_ife, input int e_isel);
    chk({tag, ".busy"}, 32'(busy), 32'(e_busy));
    chk({tag, ".done"}, 32'(done), 32'(e_done));
    chk({tag, ".clr"},  32'(clr),  32'(e_clr));
    chk({tag, ".wle"},  32'(wle),  32'(e_wle));
    chk({tag, ".wsel"}, 32'(wsel), 32'(e_wsel));
    chk({tag, ".ife"},  32'(ife),  32'(e_ife));
    chk({tag, ".isel"}, 32'(isel), 32'(e_isel));
  endtask

  // One operation started from IDLE. k counts cycles from CLEAR (k=0).
  // Column c is valid for k in [off0+c*stag, off0+c*stag+len) unless c==dead.
  // drain = hand-computed DRAIN length, so DONE is at k=9+drain.
  task automatic op(input string tag, input int off0, input int stag, input int len,
                    input int dead, input int drain, input int pulse_k, input bit hold,
                    input bit exp_tmo);
    int done_k;
    done_k = 9 + drain;
    start = 1'b1;
    tick();
    for (int k = 0; k <= done_k + 1; k++) begin
      if (k > 0) tick();
      chk_all($sformatf("%s.k%0d", tag, k), k <= done_k, k == done_k, k == 0,
              k >= 1 && k <= 4, (k >= 1 && k <= 4) ? k - 1 : 0,
              k >= 5 && k <= 8, (k >= 5 && k <= 8) ? k - 5 : 0);
      if (k > 0) chk($sformatf("%s.k%0d.tmo", tag, k), 32'(tmo), 32'((k >= done_k) ? exp_tmo : 1'b0));
      for (int c = 0; c < 4; c++)
        vld[c] = (c != dead) && (k >= off0 + c * stag) && (k < off0 + c * stag + len);
      start = hold || (k == pulse_k);
    end
    vld = '0;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; vld = '0;
    tick(); tick();
    chk_all("reset", 0, 0, 0, 0, 0, 0, 0);
    chk("reset.tmo", 32'(tmo), 32'd0);
    rst = 1'b0;
    vld = 4'hF;  // valid in IDLE must not matter
    tick();
    chk_all("idle", 0, 0, 0, 0, 0, 0, 0);
    vld = '0;

    // Staggered columns: col3 valid k=8..15, count 8 at k=16, DONE k=17.
    op("basic", 5, 1, 8, -1, 8, -1, 1'b0, 1'b0);

    // Start pulse in STREAM is ignored; exactly one done, zero drain.
    op("pulse", 0, 0, 8, -1, 0, 6, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_all($sformatf("pulse.after%0d", i), 0, 0, 0, 0, 0, 0, 0);
    end

    // Reset in LOAD_W at row 2.
    start = 1'b1; tick(); start = 1'b0;
    tick(); tick(); tick();
    chk("rst.wsel_before", 32'(wsel), 32'd2);
    rst = 1'b1; tick(); rst = 1'b0;
    chk_all("rst.now", 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 10; i++) begin
      tick();
      chk($sformatf("rst.idle%0d.done", i), 32'(done), 32'd0);
      chk($sformatf("rst.idle%0d.busy", i), 32'(busy), 32'd0);
    end

    // Valid held past the target saturates; all columns finish together in STREAM.
    op("sat", 0, 0, 12, -1, 0, -1, 1'b0, 1'b0);
    // Counts reaching 8 only after STREAM's last cycle force one DRAIN cycle.
    op("late", 1, 0, 8, -1, 1, -1, 1'b0, 1'b0);

    // Start held high: IDLE lasts one cycle between operations.
    op("hold0", 0, 0, 8, -1, 0, -1, 1'b1, 1'b0);
    op("hold1", 0, 0, 8, -1, 0, -1, 1'b1, 1'b0);
    op("hold2", 0, 0, 8, -1, 0, -1, 1'b0, 1'b0);
    tick();
    chk_all("hold.end", 0, 0, 0, 0, 0, 0, 0);

`ifdef MATMUL_SEQ_TIMEOUT_EN
    // Column 2 never valid: 16 DRAIN cycles then DONE with sticky error.
    op("tmo", 1, 0, 8, 2, 16, -1, 1'b0, 1'b1);
    tick();
    chk("tmo.sticky", 32'(tmo), 32'd1);
    op("tmo_clr", 0, 0, 8, -1, 0, -1, 1'b0, 1'b0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
